// File: rtl/bp_fpga_host_pkg.sv
// Shared types for the FPGA host-side AXI blocks: FSM state encoding and
// AXI read-response codes.
package bp_fpga_host_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'b00,
        e_ar   = 2'b01,
        e_r    = 2'b10
    } state_e;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    // Index of the winner for a one-hot two-way grant.
    function automatic logic grant_idx(input logic [1:0] grant_oh);
        return grant_oh[1];
    endfunction

endpackage

// File: rtl/bp_fpga_rr_arb2.sv
// Two-input round-robin picker: combinational, the last-served pointer is
// owned by the caller.
module bp_fpga_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the port that was not served last wins.
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bp_fpga_axi_read_mux.sv
// Two-to-one AXI4 read (AR/R) mux, one burst outstanding, round-robin grant.
// Optional R-ID checking is enabled with BP_FPGA_AXI_READ_MUX_RID_CHECK_EN.
module bp_fpga_axi_read_mux
    import bp_fpga_host_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]   s0_axi_arid,
    input  logic                      s0_axi_arlock,
    input  logic [3:0]                s0_axi_arcache,
    input  logic [2:0]                s0_axi_arprot,
    input  logic [7:0]                s0_axi_arlen,
    input  logic [2:0]                s0_axi_arsize,
    input  logic [1:0]                s0_axi_arburst,
    input  logic [3:0]                s0_axi_arqos,
    input  logic [3:0]                s0_axi_arregion,
    input  logic                      s0_axi_arvalid,
    output logic                      s0_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [AXI_ID_WIDTH-1:0]   s0_axi_rid,
    output logic                      s0_axi_rlast,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rvalid,
    input  logic                      s0_axi_rready,

    input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]   s1_axi_arid,
    input  logic                      s1_axi_arlock,
    input  logic [3:0]                s1_axi_arcache,
    input  logic [2:0]                s1_axi_arprot,
    input  logic [7:0]                s1_axi_arlen,
    input  logic [2:0]                s1_axi_arsize,
    input  logic [1:0]                s1_axi_arburst,
    input  logic [3:0]                s1_axi_arqos,
    input  logic [3:0]                s1_axi_arregion,
    input  logic                      s1_axi_arvalid,
    output logic                      s1_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [AXI_ID_WIDTH-1:0]   s1_axi_rid,
    output logic                      s1_axi_rlast,
    output logic [1:0]                s1_axi_rresp,
    output logic                      s1_axi_rvalid,
    input  logic                      s1_axi_rready,

    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic                      m_axi_rlast,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    state_e     state_r;
    logic       grant_r;
    logic       last_r;

    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic [1:0] w_arvalid;
    logic [1:0] w_rready;
    logic [1:0] w_arready;
    logic [1:0] w_rvalid;
    logic       w_in_ar;
    logic       w_in_r;
    logic       w_ar_hs;
    logic       w_r_hs;
    logic [1:0] w_rresp;

    assign w_req     = {s1_axi_arvalid, s0_axi_arvalid};
    assign w_arvalid = {s1_axi_arvalid, s0_axi_arvalid};
    assign w_rready  = {s1_axi_rready, s0_axi_rready};
    assign w_in_ar   = (state_r == e_ar);
    assign w_in_r    = (state_r == e_r);

    bp_fpga_rr_arb2 u_arb (
        .req   (w_req),
        .last  (last_r),
        .grant (w_grant)
    );

    // AR fields follow the registered grant; only arvalid is state-gated.
    always_comb begin
        m_axi_araddr   = grant_r ? s1_axi_araddr   : s0_axi_araddr;
        m_axi_arid     = grant_r ? s1_axi_arid     : s0_axi_arid;
        m_axi_arlock   = grant_r ? s1_axi_arlock   : s0_axi_arlock;
        m_axi_arcache  = grant_r ? s1_axi_arcache  : s0_axi_arcache;
        m_axi_arprot   = grant_r ? s1_axi_arprot   : s0_axi_arprot;
        m_axi_arlen    = grant_r ? s1_axi_arlen    : s0_axi_arlen;
        m_axi_arsize   = grant_r ? s1_axi_arsize   : s0_axi_arsize;
        m_axi_arburst  = grant_r ? s1_axi_arburst  : s0_axi_arburst;
        m_axi_arqos    = grant_r ? s1_axi_arqos    : s0_axi_arqos;
        m_axi_arregion = grant_r ? s1_axi_arregion : s0_axi_arregion;
    end

    assign m_axi_arvalid = w_in_ar && w_arvalid[grant_r];
    assign m_axi_rready  = w_in_r && w_rready[grant_r];
    assign w_ar_hs       = m_axi_arvalid && m_axi_arready;
    assign w_r_hs        = m_axi_rvalid && m_axi_rready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign w_arready[gi] = w_in_ar && (grant_r == 1'(gi)) && m_axi_arready;
            assign w_rvalid[gi]  = w_in_r  && (grant_r == 1'(gi)) && m_axi_rvalid;
        end
    endgenerate

    assign s0_axi_arready = w_arready[0];
    assign s1_axi_arready = w_arready[1];
    assign s0_axi_rvalid  = w_rvalid[0];
    assign s1_axi_rvalid  = w_rvalid[1];

    assign s0_axi_rdata = m_axi_rdata;
    assign s0_axi_rid   = m_axi_rid;
    assign s0_axi_rlast = m_axi_rlast;
    assign s0_axi_rresp = w_rresp;
    assign s1_axi_rdata = m_axi_rdata;
    assign s1_axi_rid   = m_axi_rid;
    assign s1_axi_rlast = m_axi_rlast;
    assign s1_axi_rresp = w_rresp;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= e_idle;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            case (state_r)
                e_idle: begin
                    if (|w_req) begin
                        grant_r <= grant_idx(w_grant);
                        state_r <= e_ar;
                    end
                end
                e_ar: begin
                    if (w_ar_hs) begin
                        state_r <= e_r;
                    end
                end
                e_r: begin
                    if (w_r_hs && m_axi_rlast) begin
                        last_r  <= grant_r;
                        state_r <= e_idle;
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

`ifdef BP_FPGA_AXI_READ_MUX_RID_CHECK_EN
    logic [AXI_ID_WIDTH-1:0] arid_r;
    logic                    rid_err_r;
    logic                    w_rid_mismatch;

    assign w_rid_mismatch = (m_axi_rid != arid_r);
    assign w_rresp        = w_rid_mismatch ? RRESP_SLVERR : m_axi_rresp;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arid_r    <= '0;
            rid_err_r <= 1'b0;
        end else begin
            if (w_in_ar && w_ar_hs) begin
                arid_r <= m_axi_arid;
            end
            if (w_r_hs && w_rid_mismatch) begin
                rid_err_r <= 1'b1;
`ifndef SYNTHESIS
                $error("bp_fpga_axi_read_mux: rid %0h does not match arid %0h", m_axi_rid, arid_r);
`endif
            end
        end
    end
`else
    assign w_rresp = m_axi_rresp;
`endif

endmodule
